// File: rtl/led_fader.sv
// rtl/led_fader.sv - per-channel PWM fader between the pattern sequencer and the LED pins
module led_fader #(
  parameter int N        = 5,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 256
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] pattern,
  output logic [N-1:0] led,
  output logic         busy
);

  localparam int                  STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE   = 1;
  localparam logic [STEP_W-1:0]   STEP_ONE  = 1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);

  logic [N-1:0]        pattern_q;
  logic [PWM_BITS-1:0] bright_q [N];
  logic [PWM_BITS-1:0] bright_d [N];
  logic [PWM_BITS-1:0] target   [N];
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [N-1:0]        led_q, led_d;
  logic                busy_q, busy_d;
  logic                tick;

  // Free-running PWM phase and brightness-step prescaler; both freeze while disabled.
  always_comb begin
    tick       = enable && (step_cnt_q == STEP_LAST);
    pwm_cnt_d  = pwm_cnt_q;
    step_cnt_d = step_cnt_q;
    if (enable) begin
      pwm_cnt_d  = pwm_cnt_q + PWM_ONE;
      step_cnt_d = tick ? '0 : step_cnt_q + STEP_ONE;
    end
  end

  // Each channel's target is full scale or dark depending on its registered pattern bit.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      target[i] = pattern_q[i] ? MAX : '0;
    end
  end

  // Step each brightness one unit toward its target on a tick; derive next LED and busy.
  always_comb begin
    bright_d = bright_q;
    led_d    = '0;
    busy_d   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (tick) begin
        if (bright_q[i] < target[i]) begin
          bright_d[i] = bright_q[i] + PWM_ONE;
        end else if (bright_q[i] > target[i]) begin
          bright_d[i] = bright_q[i] - PWM_ONE;
        end
      end
      // busy looks at the post-step value so it clears right after the final tick
      if (bright_d[i] != target[i]) begin
        busy_d = 1'b1;
      end
      // full scale is forced solid so a fully-on LED has no one-count dark gap
      if (!enable) begin
        led_d[i] = 1'b0;
      end else if (bright_q[i] == MAX) begin
        led_d[i] = 1'b1;
      end else if (bright_q[i] == '0) begin
        led_d[i] = 1'b0;
      end else begin
        led_d[i] = (pwm_cnt_q < bright_q[i]);
      end
    end
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pattern_q  <= '0;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      led_q      <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        bright_q[i] <= '0;
      end
    end else begin
      pattern_q  <= pattern;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      bright_q   <= bright_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule
